pipeline_control_unit: RTL and testbench
========================================

# pipeline_control_unit

Pipelined RISC-V RV32I control unit for the five-stage core. It decodes `op`, `funct3` and `funct7[5]` in the Decode stage into a complete, latch-free control word, including ALU control. It carries that word through ID/EX, EX/MEM and MEM/WB control registers, with a flush on the ID/EX boundary, and resolves branch/jump redirection (`PCSrcE`) in Execute from the datapath compare flags.

## Interface
- `IMM_SRC_W`, 3: width of the immediate-format select.
- `ALU_CTRL_W`, 4: width of the ALU operation code.
- `clk` in 1: core clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 7: Decode-stage opcode.
- `funct3` in 3: Decode-stage funct3.
- `funct7b5` in 1: Decode-stage instruction bit 30.
- `FlushE` in 1: clears the ID/EX control register (from the hazard unit).
- `ZeroE` in 1: ALU result zero.
- `LtE` in 1: rs1 < rs2, signed.
- `LtuE` in 1: rs1 < rs2, unsigned.
- `ImmSrcD` out `IMM_SRC_W`: immediate format, combinational; I=0, S=1, B=2, U=3, J=4.
- `IllegalD` out 1: unrecognised opcode in Decode.
- `ALUControlE` out `ALU_CTRL_W`: ALU op in Execute.
- `ALUSrcE` out 1: 1 selects the immediate as ALU operand B.
- `JalrE` out 1: branch target = rs1 + imm instead of PC + imm.
- `PCSrcE` out 1: redirect fetch (combinational from E registers and flags).
- `ResultSrcE` out 2: exported to the hazard unit for load-use detection.
- `RegWriteM` out 1: Memory-stage writeback enable.
- `MemWriteM` out 1: Memory-stage store enable.
- `ResultSrcM` out 2: Memory-stage result select.
- `RegWriteW` out 1: Writeback-stage register-file write enable.
- `ResultSrcW` out 2: Writeback-stage result select; 0=ALU, 1=memory, 2=PC+4, 3=immediate.

## Operation
- The decoder assigns every control field in every opcode case; the default case is the all-zero NOP word.
- Per-opcode control word:
  - R `0110011`: RegWrite=1, ALUSrc=0.
  - I-ALU `0010011`: RegWrite=1, ALUSrc=1, ImmSrc=I.
  - LW `0000011`: RegWrite=1, ALUSrc=1, ResultSrc=1, ImmSrc=I, ALU=ADD.
  - S `0100011`: MemWrite=1, ALUSrc=1, ImmSrc=S, ALU=ADD.
  - B `1100011`: Branch=1, ImmSrc=B, ALU=SUB.
  - JAL `1101111`: Jump=1, RegWrite=1, ResultSrc=2, ImmSrc=J.
  - JALR `1100111`: Jump=1, Jalr=1, RegWrite=1, ResultSrc=2, ALUSrc=1, ImmSrc=I.
  - LUI `0110111`: RegWrite=1, ResultSrc=3, ImmSrc=U.
- ALU codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9.
- R-type ALU code comes from funct3, with funct7b5 selecting SUB vs ADD and SRA vs SRL.
- I-type ALU code comes from funct3 with funct7b5 ignored, except that funct3=101 uses funct7b5 to select SRA vs SRL.
- `funct3` is carried into E for branch resolution:
  - 000 taken if ZeroE; 001 taken if !ZeroE.
  - 100 taken if LtE; 101 taken if !LtE.
  - 110 taken if LtuE; 111 taken if !LtuE.
  - 010 and 011 are never taken.
- `PCSrcE = JumpE | (BranchE & taken)`.

## Timing
- Decode-stage outputs are combinational.
- Latency: a decoded word appears on E outputs 1 cycle later, M outputs 2 cycles later, W outputs 3 cycles later.
- EX/MEM and MEM/WB always advance; the block has no stall inputs for them.
- Priority at each edge is `rst` > `FlushE` > load.
- On `rst`, every register is cleared to 0. After reset, all E/M/W outputs are 0 and `PCSrcE` is 0.
- A flushed E entry is a NOP: zero control, so it never writes, stores or redirects. That NOP then propagates to M and W normally.
- `FlushE` asserted in the same cycle as a taken `PCSrcE` clears ID/EX normally. The redirect already issued on `PCSrcE` stands.
- Reset asserted mid-pipeline discards all in-flight control.

## Configuration
- `RV_ILLEGAL_DETECT_EN` defined:
  - `IllegalD` = 1 for any opcode outside the eight listed.
  - The word is forced to NOP.
  - `IllegalD` is carried through the pipeline registers, and a flush clears it.
- `RV_ILLEGAL_DETECT_EN` undefined: `IllegalD` is tied 0; unknown opcodes still decode to NOP.

## Structure
- Shared package `rv_ctrl_pkg` holds:
  - opcode constants;
  - ALU code constants;
  - ImmSrc and ResultSrc encodings;
  - a packed `ctrl_word_t` struct (RegWrite, MemWrite, ResultSrc, Jump, Branch, Jalr, ALUSrc, ALUControl, funct3, Illegal).
- Sub-module `main_alu_decoder` is purely combinational (op/funct3/funct7b5 → `ctrl_word_t`, ImmSrc). The top level holds the three pipeline registers and branch resolution.

## Test plan
- Reset: assert `rst` with `op`=R-type → all E/M/W outputs 0 and `PCSrcE`=0 during reset and one cycle after release.
- R-type SUB (`op`=0110011, `funct3`=000, `funct7b5`=1) → `ALUControlE`=1 next cycle; `RegWriteW`=1 three cycles after decode.
- BNE (`funct3`=001) with `ZeroE`=0 in E → `PCSrcE`=1. Repeat with `ZeroE`=1 → `PCSrcE`=0. BGEU with `LtuE`=0 → `PCSrcE`=1.
- LW followed by `FlushE`: `ResultSrcE`=1 for one cycle. The flushed entry yields `RegWriteM`=0 and `ResultSrcM`=0.
- JALR → `JalrE`=1, `PCSrcE`=1, `ALUSrcE`=1; `ResultSrcW`=2 and `RegWriteW`=1 three cycles after decode.
- `op`=1111111 with the macro defined → `IllegalD`=1 and NOP word, with `RegWriteW`=0. Without the macro → `IllegalD`=0 and NOP word.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared encodings and control-word types for the RV32I pipeline control unit
// Contents: opcode constants, ALU operation codes, immediate/result-select
// encodings, the decoded control word carried through the pipeline, and the
// reduced Memory/Writeback control records.
package rv_ctrl_pkg;

  localparam int IMM_W = 3;
  localparam int ALU_W = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I_ALU = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'd5;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'd7;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'd8;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'd9;

  typedef enum logic [IMM_W-1:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2,
    RES_IMM = 2'd3
  } result_src_e;

  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic [1:0]       result_src;
    logic             jump;
    logic             branch;
    logic             jalr;
    logic             alu_src;
    logic [ALU_W-1:0] alu_control;
    logic [2:0]       funct3;
    logic             illegal;
  } ctrl_word_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       illegal;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       illegal;
  } ctrl_w_t;

  // Shared by R-type and I-type: only R-type uses funct7b5 for SUB, both use
  // it to pick arithmetic vs logical right shift.
  function automatic logic [ALU_W-1:0] alu_decode(input logic [2:0] f3,
                                                  input logic       f7b5,
                                                  input logic       is_r);
    logic [ALU_W-1:0] code;
    code = ALU_ADD;
    case (f3)
      3'b000: code = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001: code = ALU_SLL;
      3'b010: code = ALU_SLT;
      3'b011: code = ALU_SLTU;
      3'b100: code = ALU_XOR;
      3'b101: code = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110: code = ALU_OR;
      3'b111: code = ALU_AND;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/main_alu_decoder.sv
// rtl/main_alu_decoder.sv - combinational main + ALU decoder for the Decode stage
// Ports: op/funct3/funct7b5 (instruction fields) in; ctrl (full control word)
// and imm_src (immediate format) out.
// Build option: RV_ILLEGAL_DETECT_EN flags unknown opcodes in ctrl.illegal.
module main_alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  output ctrl_word_t       ctrl,
  output logic [IMM_W-1:0] imm_src
);

  always_comb begin
    ctrl    = '0;
    imm_src = IMM_I;
    case (op)
      OP_R: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = alu_decode(funct3, funct7b5, 1'b1);
        ctrl.funct3      = funct3;
      end
      OP_I_ALU: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = alu_decode(funct3, funct7b5, 1'b0);
        ctrl.funct3      = funct3;
        imm_src          = IMM_I;
      end
      OP_LOAD: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.result_src  = RES_MEM;
        ctrl.alu_control = ALU_ADD;
        ctrl.funct3      = funct3;
        imm_src          = IMM_I;
      end
      OP_STORE: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADD;
        ctrl.funct3      = funct3;
        imm_src          = IMM_S;
      end
      OP_BRANCH: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
        ctrl.funct3      = funct3;
        imm_src          = IMM_B;
      end
      OP_JAL: begin
        ctrl.jump        = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.result_src  = RES_PC4;
        ctrl.funct3      = funct3;
        imm_src          = IMM_J;
      end
      OP_JALR: begin
        ctrl.jump        = 1'b1;
        ctrl.jalr        = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.result_src  = RES_PC4;
        ctrl.alu_src     = 1'b1;
        ctrl.funct3      = funct3;
        imm_src          = IMM_I;
      end
      OP_LUI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.result_src  = RES_IMM;
        ctrl.funct3      = funct3;
        imm_src          = IMM_U;
      end
      default: begin
        // Unknown opcodes always decode to the all-zero NOP word.
`ifdef RV_ILLEGAL_DETECT_EN
        ctrl.illegal = 1'b1;
`else
        ctrl.illegal = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - RV32I five-stage control unit: decode, ID/EX/MEM/WB control registers, branch resolution
// Ports: clk, rst (sync, active high); Decode inputs op/funct3/funct7b5;
// FlushE clears ID/EX; ZeroE/LtE/LtuE compare flags from Execute.
// Outputs: ImmSrcD/IllegalD (combinational Decode), Execute controls and
// PCSrcE, Memory controls, Writeback controls.
// Build option: RV_ILLEGAL_DETECT_EN enables IllegalD for unknown opcodes.
module pipeline_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int IMM_SRC_W  = 3,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  FlushE,
  input  logic                  ZeroE,
  input  logic                  LtE,
  input  logic                  LtuE,
  output logic [IMM_SRC_W-1:0]  ImmSrcD,
  output logic                  IllegalD,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  ALUSrcE,
  output logic                  JalrE,
  output logic                  PCSrcE,
  output logic [1:0]            ResultSrcE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcM,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW
);

  ctrl_word_t       ctrl_d;
  logic [IMM_W-1:0] imm_src_d;
  ctrl_word_t       e_q;
  ctrl_m_t          m_q;
  ctrl_w_t          w_q;
  logic             taken_e;

  main_alu_decoder u_dec (
    .op       (op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .ctrl     (ctrl_d),
    .imm_src  (imm_src_d)
  );

  assign ImmSrcD  = imm_src_d;
  assign IllegalD = ctrl_d.illegal;

  // ID/EX: a flush loads the NOP word, so the squashed slot can never write,
  // store or redirect as it moves on to M and W.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= '0;
    end else if (FlushE) begin
      e_q <= '0;
    end else begin
      e_q <= ctrl_d;
    end
  end

  // EX/MEM and MEM/WB have no stall path; they advance every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
      w_q <= '0;
    end else begin
      m_q.reg_write  <= e_q.reg_write;
      m_q.mem_write  <= e_q.mem_write;
      m_q.result_src <= e_q.result_src;
      m_q.illegal    <= e_q.illegal;
      w_q.reg_write  <= m_q.reg_write;
      w_q.result_src <= m_q.result_src;
      w_q.illegal    <= m_q.illegal;
    end
  end

  // Branch condition from funct3; 010/011 are not branch encodings.
  always_comb begin
    taken_e = 1'b0;
    case (e_q.funct3)
      3'b000:  taken_e = ZeroE;
      3'b001:  taken_e = ~ZeroE;
      3'b100:  taken_e = LtE;
      3'b101:  taken_e = ~LtE;
      3'b110:  taken_e = LtuE;
      3'b111:  taken_e = ~LtuE;
      default: taken_e = 1'b0;
    endcase
  end

  assign PCSrcE      = e_q.jump | (e_q.branch & taken_e);
  assign ALUControlE = e_q.alu_control;
  assign ALUSrcE     = e_q.alu_src;
  assign JalrE       = e_q.jalr;
  assign ResultSrcE  = e_q.result_src;

  assign RegWriteM   = m_q.reg_write;
  assign MemWriteM   = m_q.mem_write;
  assign ResultSrcM  = m_q.result_src;

  assign RegWriteW   = w_q.reg_write;
  assign ResultSrcW  = w_q.result_src;

  // The illegal flag reaches Writeback for a future trap hook; nothing
  // consumes it at this level yet.
  logic unused_w_illegal;
  assign unused_w_illegal = w_q.illegal;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb/tb_pipeline_control_unit.sv - scoreboard bench for pipeline_control_unit
module tb_pipeline_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       FlushE, ZeroE, LtE, LtuE;
  logic [2:0] ImmSrcD;
  logic       IllegalD;
  logic [3:0] ALUControlE;
  logic       ALUSrcE, JalrE, PCSrcE;
  logic [1:0] ResultSrcE;
  logic       RegWriteM, MemWriteM;
  logic [1:0] ResultSrcM;
  logic       RegWriteW;
  logic [1:0] ResultSrcW;

  always #5 clk = ~clk;

  pipeline_control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .FlushE      (FlushE),
    .ZeroE       (ZeroE),
    .LtE         (LtE),
    .LtuE        (LtuE),
    .ImmSrcD     (ImmSrcD),
    .IllegalD    (IllegalD),
    .ALUControlE (ALUControlE),
    .ALUSrcE     (ALUSrcE),
    .JalrE       (JalrE),
    .PCSrcE      (PCSrcE),
    .ResultSrcE  (ResultSrcE),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW)
  );

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic [1:0] rs;
    logic       jump;
    logic       branch;
    logic       jalr;
    logic       alusrc;
    logic [3:0] alu;
    logic [2:0] f3;
    logic [2:0] imm;
    logic       has_imm;
    logic       illegal;
  } exp_t;

  localparam exp_t NOP = '0;

  exp_t q_m[$];
  exp_t q_w[$];
  exp_t cur_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] alu_base(input logic [2:0] f3);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    return tbl[f3];
  endfunction

  function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    exp_t e;
    e = NOP;
    e.f3 = f3;
    case (o)
      7'b0110011: begin
        e.rw = 1;
        e.alu = (f3 == 3'b000 && f7) ? 4'd1 : (f3 == 3'b101 && f7) ? 4'd9 : alu_base(f3);
      end
      7'b0010011: begin
        e.rw = 1; e.alusrc = 1; e.imm = 0; e.has_imm = 1;
        e.alu = (f3 == 3'b101 && f7) ? 4'd9 : alu_base(f3);
      end
      7'b0000011: begin e.rw = 1; e.alusrc = 1; e.rs = 1; e.imm = 0; e.has_imm = 1; end
      7'b0100011: begin e.mw = 1; e.alusrc = 1; e.imm = 1; e.has_imm = 1; end
      7'b1100011: begin e.branch = 1; e.imm = 2; e.alu = 4'd1; e.has_imm = 1; end
      7'b1101111: begin e.jump = 1; e.rw = 1; e.rs = 2; e.imm = 4; e.has_imm = 1; end
      7'b1100111: begin e.jump = 1; e.jalr = 1; e.rw = 1; e.rs = 2; e.alusrc = 1; e.imm = 0; e.has_imm = 1; end
      7'b0110111: begin e.rw = 1; e.rs = 3; e.imm = 3; e.has_imm = 1; end
      default: begin
        e = NOP;
`ifdef RV_ILLEGAL_DETECT_EN
        e.illegal = 1;
`endif
      end
    endcase
    return e;
  endfunction

  function automatic logic exp_pcsrc(input exp_t e, input logic z, input logic lt, input logic ltu);
    logic cond;
    case (e.f3[2:1])
      2'b00:   cond = z ^ e.f3[0];
      2'b10:   cond = lt ^ e.f3[0];
      2'b11:   cond = ltu ^ e.f3[0];
      default: cond = 1'b0;
    endcase
    return e.jump | (e.branch & cond);
  endfunction

  // One cycle: drive Decode inputs plus flags for the instruction now in E,
  // check Decode outputs and PCSrcE, then check E/M/W after the edge.
  task automatic step(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic fl, input logic z, input logic lt, input logic ltu,
                      input logic r);
    exp_t d, m_rec, w_rec;
    @(negedge clk);
    op = o; funct3 = f3; funct7b5 = f7; FlushE = fl;
    ZeroE = z; LtE = lt; LtuE = ltu; rst = r;
    #1;
    d = model(o, f3, f7);
    if (d.has_imm) check("ImmSrcD", 8'(ImmSrcD), 8'(d.imm));
    check("IllegalD", 8'(IllegalD), 8'(d.illegal));
    check("PCSrcE", 8'(PCSrcE), 8'(exp_pcsrc(cur_e, z, lt, ltu)));
    @(posedge clk);
    #1;
    m_rec = q_m.pop_front();
    w_rec = q_w.pop_front();
    if (r) begin
      cur_e = NOP; m_rec = NOP; w_rec = NOP;
    end else begin
      cur_e = fl ? NOP : d;
    end
    check("ALUControlE", 8'(ALUControlE), 8'(cur_e.alu));
    check("ALUSrcE", 8'(ALUSrcE), 8'(cur_e.alusrc));
    check("JalrE", 8'(JalrE), 8'(cur_e.jalr));
    check("ResultSrcE", 8'(ResultSrcE), 8'(cur_e.rs));
    check("RegWriteM", 8'(RegWriteM), 8'(m_rec.rw));
    check("MemWriteM", 8'(MemWriteM), 8'(m_rec.mw));
    check("ResultSrcM", 8'(ResultSrcM), 8'(m_rec.rs));
    check("RegWriteW", 8'(RegWriteW), 8'(w_rec.rw));
    check("ResultSrcW", 8'(ResultSrcW), 8'(w_rec.rs));
    q_w.push_back(m_rec);
    q_m.push_back(cur_e);
  endtask

  logic [6:0] ops [9];

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111};
    rst = 1; op = 7'b0110011; funct3 = 0; funct7b5 = 0;
    FlushE = 0; ZeroE = 0; LtE = 0; LtuE = 0;
    cur_e = NOP;
    q_m.push_back(NOP);
    q_w.push_back(NOP);

    // reset with R-type on the decode inputs, then release
    step(7'b0110011, 3'b000, 0, 0, 0, 0, 0, 1);
    step(7'b0110011, 3'b000, 0, 0, 0, 0, 0, 1);
    step(7'b0110011, 3'b000, 0, 0, 0, 0, 0, 0);

    // R-type SUB, SRA, AND; I-type ADDI with bit30 set, SRAI, SLTIU
    step(7'b0110011, 3'b000, 1, 0, 0, 0, 0, 0);
    step(7'b0110011, 3'b101, 1, 0, 0, 0, 0, 0);
    step(7'b0110011, 3'b111, 0, 0, 0, 0, 0, 0);
    step(7'b0010011, 3'b000, 1, 0, 0, 0, 0, 0);
    step(7'b0010011, 3'b101, 1, 0, 0, 0, 0, 0);
    step(7'b0010011, 3'b011, 0, 0, 0, 0, 0, 0);

    // BNE taken (ZeroE=0), BNE not taken (ZeroE=1), BGEU taken (LtuE=0)
    step(7'b1100011, 3'b001, 0, 0, 0, 0, 0, 0);
    step(7'b1100011, 3'b001, 0, 0, 0, 0, 0, 0);
    step(7'b1100011, 3'b111, 0, 0, 1, 0, 0, 0);
    step(7'b1100011, 3'b100, 0, 0, 0, 0, 0, 0);
    step(7'b1100011, 3'b010, 0, 0, 1, 1, 0, 0);
    step(7'b0110011, 3'b000, 0, 0, 1, 1, 1, 0);

    // LW then a flushed ADD
    step(7'b0000011, 3'b010, 0, 0, 0, 0, 0, 0);
    step(7'b0110011, 3'b000, 0, 1, 0, 0, 0, 0);
    step(7'b0110011, 3'b000, 0, 0, 0, 0, 0, 0);

    // JALR, JAL with flush in the cycle it redirects, LUI, SW
    step(7'b1100111, 3'b000, 0, 0, 0, 0, 0, 0);
    step(7'b1101111, 3'b000, 0, 0, 0, 0, 0, 0);
    step(7'b0110111, 3'b000, 0, 1, 0, 0, 0, 0);
    step(7'b0100011, 3'b010, 0, 0, 0, 0, 0, 0);

    // unknown opcode followed by drains
    step(7'b1111111, 3'b000, 0, 0, 0, 0, 0, 0);
    step(7'b0110011, 3'b000, 0, 0, 0, 0, 0, 0);
    step(7'b0110011, 3'b000, 0, 0, 0, 0, 0, 0);
    step(7'b0110011, 3'b000, 0, 0, 0, 0, 0, 0);

    // reset mid-pipeline with live control in flight
    step(7'b1101111, 3'b000, 0, 0, 0, 0, 0, 0);
    step(7'b0000011, 3'b010, 0, 0, 0, 0, 0, 0);
    step(7'b1100111, 3'b000, 0, 0, 0, 0, 0, 1);
    step(7'b0110011, 3'b000, 0, 0, 0, 0, 0, 0);

    // random mix
    for (int i = 0; i < 60; i++) begin
      step(ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
